// File: rtl/ahb_sched_pkg.sv
// Shared types and constants for the AHB read/write scheduler.
package ahb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } sched_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/ahb_addr_ctr.sv
// Loadable word pointer plus transfer counter for one direction of a frame.
// The pointer advances by one word per completed transfer and wraps silently.
module ahb_addr_ctr
  import ahb_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] base,
  input  logic              inc,
  input  logic [CNT_W-1:0]  limit,
  output logic [ADDR_W-1:0] ptr,
  output logic              reached,
  output logic              last
);

  logic [CNT_W-1:0] cnt;

  // Load on frame start, otherwise step once per completed transfer.
  // The reached guard keeps the count from ever passing the frame length.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr <= '0;
      cnt <= '0;
    end else if (load) begin
      ptr <= base;
      cnt <= '0;
    end else if (inc && !reached) begin
      ptr <= ptr + ADDR_W'(WORD_BYTES);
      cnt <= cnt + CNT_W'(1);
    end
  end

  // last is widened by one bit so a full-scale limit does not alias to zero.
  always_comb begin
    reached = (cnt == limit);
    last    = ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) == (CNT_W+1)'(limit);
  end

endmodule

// File: rtl/ahb_rw_scheduler.sv
// Arbitrates the shared AHB-Lite master port between the pixel-fetch reads
// and the result write-back writes, one non-pipelined NONSEQ at a time.
//
// state | meaning
// IDLE  | waiting for start; no frame in progress
// ARB   | pick read or write among eligible requests; htrans=IDLE
// ADDR  | address phase, NONSEQ on the bus, held until hready
// DATA  | data phase, waiting for hready to complete the transfer
module ahb_rw_scheduler
  import ahb_sched_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  output logic              busy,
  output logic              done
);

  sched_state_t      state;
  logic [CNT_W-1:0]  num_reg;
  logic              last_grant;   // 1 = last grant was a write
  logic              xfer_wr;      // direction of the transfer in flight

  logic              ctr_load;
  logic              rd_inc;
  logic              wr_inc;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              rd_reached;
  logic              wr_reached;
  logic              wr_last;
  logic              rd_last_unused; // read completion never ends a frame

  logic              rd_elig;
  logic              wr_elig;
  logic              pick_wr;

  // Counter strobes and arbitration decision for the current cycle.
  always_comb begin
    ctr_load = (state == IDLE) && start;
    rd_inc   = (state == DATA) && hready && !xfer_wr;
    wr_inc   = (state == DATA) && hready && xfer_wr;
    rd_elig  = rd_req && !rd_reached;
    wr_elig  = wr_req && !wr_reached;
    // With both eligible, alternate away from whoever won last time.
    pick_wr  = wr_elig && (!rd_elig || !last_grant);
  end

  ahb_addr_ctr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_rd_ctr (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (ctr_load),
    .base    (rd_base),
    .inc     (rd_inc),
    .limit   (num_reg),
    .ptr     (rd_ptr),
    .reached (rd_reached),
    .last    (rd_last_unused)
  );

  ahb_addr_ctr #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_wr_ctr (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (ctr_load),
    .base    (wr_base),
    .inc     (wr_inc),
    .limit   (num_reg),
    .ptr     (wr_ptr),
    .reached (wr_reached),
    .last    (wr_last)
  );

  // Sequencer and registered bus/handshake outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      num_reg    <= '0;
      last_grant <= 1'b1;
      xfer_wr    <= 1'b0;
      haddr      <= '0;
      htrans     <= HTRANS_IDLE;
      hwrite     <= 1'b0;
      hwdata     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      wr_ack     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      wr_ack   <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            num_reg    <= num_words;
            last_grant <= 1'b1;
            if (num_words == '0) begin
              done <= 1'b1;
              busy <= 1'b0;
            end else begin
              busy  <= 1'b1;
              state <= ARB;
            end
          end
        end
        ARB: begin
          if (rd_elig || wr_elig) begin
            xfer_wr    <= pick_wr;
            last_grant <= pick_wr;
            hwrite     <= pick_wr;
            haddr      <= pick_wr ? wr_ptr : rd_ptr;
            htrans     <= HTRANS_NONSEQ;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (hready) begin
            htrans <= HTRANS_IDLE;
            if (xfer_wr) hwdata <= wr_data;
            state <= DATA;
          end
        end
        DATA: begin
          if (hready) begin
            if (!xfer_wr) begin
              rd_data  <= hrdata;
              rd_valid <= 1'b1;
              state    <= ARB;
            end else begin
              wr_ack <= 1'b1;
              if (wr_last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= ARB;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rw_scheduler.sv
// Directed bench for ahb_rw_scheduler: reset, empty frame, reads, interleaved
// frame, wait states, ignored start and mid-transfer reset.
module tb_ahb_rw_scheduler;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [31:0] rd_base;
  logic [31:0] wr_base;
  logic [15:0] num_words;
  logic        rd_req;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_rw_scheduler dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .rd_base   (rd_base),
    .wr_base   (wr_base),
    .num_words (num_words),
    .rd_req    (rd_req),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_req    (wr_req),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    n_rst = 1'b0; start = 1'b0; rd_base = '0; wr_base = '0; num_words = '0;
    rd_req = 1'b0; wr_req = 1'b0; wr_data = '0; hrdata = '0; hready = 1'b1;

    // Reset values
    #12;
    check("rst_haddr", haddr, 0);
    check("rst_htrans", htrans, 0);
    check("rst_hwrite", hwrite, 0);
    check("rst_hwdata", hwdata, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();
    n_rst = 1'b1;
    step();

    // Empty frame: done next cycle, no bus activity
    num_words = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done", done, 1);
    check("zero_htrans", htrans, 0);
    step();
    check("zero_done_end", done, 0);
    check("zero_htrans2", htrans, 0);

    // Two reads at 0x1000 / 0x1004
    rd_base = 32'h1000; wr_base = 32'h3000; num_words = 16'd2;
    rd_req = 1'b1; hrdata = 32'hAA; start = 1'b1;
    step();
    start = 1'b0;
    check("rd_busy", busy, 1);
    check("rd_arb_htrans", htrans, 0);
    step();
    check("rd0_htrans", htrans, 2);
    check("rd0_haddr", haddr, 32'h1000);
    check("rd0_hwrite", hwrite, 0);
    step();
    check("rd0_data_htrans", htrans, 0);
    check("rd0_valid_early", rd_valid, 0);
    step();
    check("rd0_valid", rd_valid, 1);
    check("rd0_rdata", rd_data, 32'hAA);
    hrdata = 32'hBB;
    step();
    check("rd1_htrans", htrans, 2);
    check("rd1_haddr", haddr, 32'h1004);
    step();
    step();
    check("rd1_valid", rd_valid, 1);
    check("rd1_rdata", rd_data, 32'hBB);
    step();
    check("rd_park_htrans", htrans, 0);
    check("rd_park_valid", rd_valid, 0);
    check("rd_park_busy", busy, 1);

    // start while busy is ignored: writes still go to 0x3000 and end after 2
    start = 1'b1; rd_base = 32'h5000; wr_base = 32'h6000; num_words = 16'd5;
    step();
    start = 1'b0;
    check("ign_htrans", htrans, 0);
    rd_req = 1'b0; wr_req = 1'b1; wr_data = 32'h11;
    step();
    check("ign_w0_haddr", haddr, 32'h3000);
    check("ign_w0_hwrite", hwrite, 1);
    check("ign_w0_htrans", htrans, 2);
    step();
    check("ign_w0_hwdata", hwdata, 32'h11);
    step();
    check("ign_w0_ack", wr_ack, 1);
    check("ign_w0_done", done, 0);
    wr_data = 32'h22;
    step();
    check("ign_w1_haddr", haddr, 32'h3004);
    step();
    check("ign_w1_hwdata", hwdata, 32'h22);
    step();
    check("ign_w1_ack", wr_ack, 1);
    check("ign_w1_done", done, 1);
    check("ign_w1_busy", busy, 0);
    wr_req = 1'b0;
    step();
    check("ign_done_end", done, 0);
    check("ign_idle_htrans", htrans, 0);

    // Interleaved frame: R,W,R,W,R,W
    rd_base = 32'h1000; wr_base = 32'h2000; num_words = 16'd3;
    rd_req = 1'b1; wr_req = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      hrdata  = 32'h100 + 32'(i);
      wr_data = 32'h200 + 32'(i);
      step();
      check("il_htrans", htrans, 2);
      check("il_hwrite", hwrite, (i % 2));
      check("il_haddr", haddr, ((i % 2) ? 32'h2000 : 32'h1000) + 32'(4 * (i / 2)));
      step();
      if (i % 2) check("il_hwdata", hwdata, 32'h200 + 32'(i));
      step();
      check("il_rd_valid", rd_valid, ((i % 2) == 0));
      check("il_wr_ack", wr_ack, (i % 2));
      check("il_done", done, (i == 5));
      if ((i % 2) == 0) check("il_rd_data", rd_data, 32'h100 + 32'(i));
    end
    check("il_busy_end", busy, 0);
    rd_req = 1'b0; wr_req = 1'b0;
    step();

    // Wait states: 2 in ADDR, 3 in DATA
    wr_base = 32'h4000; num_words = 16'd1; wr_req = 1'b1; wr_data = 32'h55; start = 1'b1;
    step();
    start = 1'b0;
    step();
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step();
      check("ws_addr_htrans", htrans, 2);
      check("ws_addr_haddr", haddr, 32'h4000);
      check("ws_addr_hwrite", hwrite, 1);
    end
    hready = 1'b1;
    step();
    check("ws_data_htrans", htrans, 0);
    check("ws_data_hwdata", hwdata, 32'h55);
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("ws_data_noack", wr_ack, 0);
      check("ws_data_haddr", haddr, 32'h4000);
    end
    hready = 1'b1;
    step();
    check("ws_ack", wr_ack, 1);
    check("ws_done", done, 1);
    wr_req = 1'b0;
    step();

    // Reset during the DATA phase of a write
    wr_base = 32'h7000; num_words = 16'd1; wr_req = 1'b1; wr_data = 32'h77; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rstd_busy_pre", busy, 1);
    check("rstd_hwdata_pre", hwdata, 32'h77);
    n_rst = 1'b0;
    #1;
    check("rstd_haddr", haddr, 0);
    check("rstd_hwrite", hwrite, 0);
    check("rstd_hwdata", hwdata, 0);
    check("rstd_htrans", htrans, 0);
    check("rstd_busy", busy, 0);
    check("rstd_wr_ack", wr_ack, 0);
    step();
    n_rst = 1'b1;
    step();
    check("rstd_idle_htrans", htrans, 0);
    step();
    check("rstd_idle_htrans2", htrans, 0);
    check("rstd_idle_busy", busy, 0);
    wr_base = 32'h7100; start = 1'b1;
    step();
    start = 1'b0;
    check("rstd_new_busy", busy, 1);
    step();
    check("rstd_new_haddr", haddr, 32'h7100);
    check("rstd_new_htrans", htrans, 2);
    step();
    step();
    check("rstd_new_ack", wr_ack, 1);
    check("rstd_new_done", done, 1);
    wr_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
